// File: rtl/uart_pkg.sv
// Shared definitions for the PMOD UART receive path: FSM encoding and
// default line parameters for the EEMBC command channel.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam logic [7:0]  UART_EOL_DEFAULT          = 8'h25;
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input bit; the reset
// value is a parameter so idle-high and idle-low lines both come up quiet.
module sync_bit #(
    parameter int unsigned STAGES = 2,
    parameter logic        INIT   = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            chain_q <= {STAGES{INIT}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pmod_uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop detection feeding a single
// holding register exposed as an AXI-Stream-style master with tlast on EOL_CHAR.
module pmod_uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0]  EOL_CHAR     = UART_EOL_DEFAULT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       pmod_uart_rxd,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic rx_s;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;

    logic [7:0] tdata_q, tdata_d;
    logic       tvalid_q, tvalid_d;
    logic       tlast_q, tlast_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;

    logic stop_done;
    logic byte_ok;

    sync_bit #(
        .STAGES (SYNC_STAGES),
        .INIT   (1'b1)
    ) u_rxd_sync (
        .clk  (sys_clock),
        .srst (reset),
        .d_i  (pmod_uart_rxd),
        .q_o  (rx_s)
    );

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                // Return to IDLE on the stop sample itself so the next start
                // edge is seen within the second half of the stop bit.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_BREAK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stop_done = (state_q == ST_STOP) && (cnt_q == CNT_LAST);
        byte_ok   = stop_done && rx_s;
        ferr_d    = stop_done && !rx_s;
        ovr_d     = 1'b0;
        tvalid_d  = tvalid_q && !m_tready;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        // Accepting the held byte in the same cycle frees the register for the new one.
        if (byte_ok) begin
            if (!tvalid_q || m_tready) begin
                tvalid_d = 1'b1;
                tdata_d  = shift_q;
                tlast_d  = (shift_q == EOL_CHAR);
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign m_tlast   = tlast_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pmod_uart_rx.sv
// Directed bench for pmod_uart_rx at 16 clocks per bit: normal bytes, EOL,
// glitch rejection, framing error with held break, overrun and mid-frame reset.
module tb_pmod_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int         cycle_cnt = 0;
    int         start_cyc = 0;
    int         n_xfer    = 0;
    int         n_ferr    = 0;
    int         n_ovr     = 0;
    int         n_badp    = 0;
    logic [7:0] xd [64];
    logic       xl [64];
    int         xc [64];
    logic       ferr_prev = 1'b0;
    logic       ovr_prev  = 1'b0;

    int b_x, b_f, b_o;

    always #5 clk = ~clk;

    pmod_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .EOL_CHAR     (8'h25),
        .SYNC_STAGES  (2)
    ) dut (
        .sys_clock     (clk),
        .reset         (reset),
        .pmod_uart_rxd (rxd),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Record every accepted byte and every error pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            xd[n_xfer[5:0]] <= m_tdata;
            xl[n_xfer[5:0]] <= m_tlast;
            xc[n_xfer[5:0]] <= cycle_cnt;
            n_xfer <= n_xfer + 1;
            $display("xfer %0d: data=%02h last=%0b cycle=%0d", n_xfer, m_tdata, m_tlast, cycle_cnt);
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (overrun)   n_ovr  <= n_ovr + 1;
        if ((frame_err && ferr_prev) || (overrun && ovr_prev) || (frame_err && overrun))
            n_badp <= n_badp + 1;
        ferr_prev <= frame_err;
        ovr_prev  <= overrun;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_x = n_xfer;
        b_f = n_ferr;
        b_o = n_ovr;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        start_cyc = cycle_cnt;
        rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(CPB);
        end
        rxd = stop_bit;
        wait_cyc(stop_len);
        rxd = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, CPB);
    endtask

    task automatic expect_one(input string tag, input logic [7:0] b, input logic last);
        check({tag, "_count"}, 32'(n_xfer - b_x), 32'd1);
        check({tag, "_data"},  32'(xd[b_x[5:0]]), 32'(b));
        check({tag, "_last"},  32'(xl[b_x[5:0]]), 32'(last));
    endtask

    initial begin
        int lat;
        reset    = 1'b1;
        rxd      = 1'b1;
        m_tready = 1'b1;
        wait_cyc(5);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata",  32'(m_tdata),  32'd0);
        check("rst_tlast",  32'(m_tlast),  32'd0);
        check("rst_ferr",   32'(frame_err), 32'd0);
        check("rst_ovr",    32'(overrun),  32'd0);
        reset = 1'b0;
        wait_cyc(10);

        // 0x55 with latency measured from the falling edge of the start bit
        snap();
        send_byte(8'h55);
        wait_cyc(20);
        expect_one("b55", 8'h55, 1'b0);
        lat = xc[b_x[5:0]] - start_cyc;
        $display("latency 0x55: %0d cycles", lat);
        check("b55_latency_window", 32'((lat >= 152 && lat <= 158) ? 1 : 0), 32'd1);
        check("b55_ferr", 32'(n_ferr - b_f), 32'd0);
        check("b55_ovr",  32'(n_ovr - b_o),  32'd0);

        // EOL then newline, back to back
        snap();
        send_byte(8'h25);
        send_byte(8'h0A);
        wait_cyc(20);
        check("b2b_count", 32'(n_xfer - b_x), 32'd2);
        check("b2b_d0", 32'(xd[b_x[5:0]]), 32'h25);
        check("b2b_l0", 32'(xl[b_x[5:0]]), 32'd1);
        check("b2b_d1", 32'(xd[(b_x + 1) & 63]), 32'h0A);
        check("b2b_l1", 32'(xl[(b_x + 1) & 63]), 32'd0);

        // Short low glitch must be rejected silently
        snap();
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(40);
        check("glitch_xfer", 32'(n_xfer - b_x), 32'd0);
        check("glitch_ferr", 32'(n_ferr - b_f), 32'd0);
        snap();
        send_byte(8'h3C);
        wait_cyc(20);
        expect_one("b3c", 8'h3C, 1'b0);

        // Low stop bit followed by a held break
        snap();
        send_frame(8'hA3, 1'b0, CPB + 48);
        wait_cyc(40);
        check("ferr_pulses", 32'(n_ferr - b_f), 32'd1);
        check("ferr_xfer",   32'(n_xfer - b_x), 32'd0);
        check("ferr_ovr",    32'(n_ovr - b_o),  32'd0);
        snap();
        send_byte(8'h12);
        wait_cyc(20);
        expect_one("b12", 8'h12, 1'b0);

        // Overrun: second byte arrives while the first is still held
        snap();
        m_tready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        wait_cyc(10);
        check("ovr_tvalid", 32'(m_tvalid), 32'd1);
        check("ovr_tdata",  32'(m_tdata),  32'h01);
        check("ovr_pulses", 32'(n_ovr - b_o), 32'd1);
        check("ovr_xfer",   32'(n_xfer - b_x), 32'd0);
        m_tready = 1'b1;
        wait_cyc(10);
        expect_one("ovr_drain", 8'h01, 1'b0);
        check("ovr_tvalid_low", 32'(m_tvalid), 32'd0);

        // Reset mid-DATA discards both the partial byte and a held byte
        snap();
        m_tready = 1'b0;
        send_byte(8'h25);
        wait_cyc(10);
        check("hold_tvalid", 32'(m_tvalid), 32'd1);
        check("hold_tlast",  32'(m_tlast),  32'd1);
        fork
            send_byte(8'hFF);
            begin
                wait_cyc(60);
                reset = 1'b1;
                wait_cyc(1);
                reset = 1'b0;
                check("mrst_tvalid", 32'(m_tvalid), 32'd0);
                check("mrst_tdata",  32'(m_tdata),  32'd0);
                check("mrst_tlast",  32'(m_tlast),  32'd0);
            end
        join
        m_tready = 1'b1;
        wait_cyc(20);
        check("mrst_xfer", 32'(n_xfer - b_x), 32'd0);
        check("mrst_ferr", 32'(n_ferr - b_f), 32'd0);
        check("mrst_ovr",  32'(n_ovr - b_o),  32'd0);
        snap();
        send_byte(8'hC3);
        wait_cyc(20);
        expect_one("bc3", 8'hC3, 1'b0);

        check("pulse_shape", 32'(n_badp), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
